regfile_scoreboard: RTL

Parametrised successor to the team's 16x16 register file. Adds configurable data width and depth, a per-register busy scoreboard for multi-cycle producers, an outstanding-reservation counter, an optional hard-wired zero register, and compile-time write-to-read forwarding. Sits between decode/issue and the ALU/memory writeback path in the datapath. Issue reserves a destination, readers see busy status, and writeback releases the register.

---
 rtl/regfile_scoreboard.sv | 122 ++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with per-register busy scoreboard
//
// Purpose: 2^ADDR_W x DATA_W register file. Issue reserves a destination
// (busy bit set), readers see busy status, and a writeback write both stores
// data and releases the register. BusyCount tracks outstanding reservations.
//
// Optional feature macro: REGFILE_SCOREBOARD_BYPASS_EN
//   defined   - a same-cycle write is forwarded to a matching read port
//               (data = WriteData, busy = 0)
//   undefined - reads return stored data and the registered busy bit
//
// Parameters:
//   DATA_W    register width
//   ADDR_W    select width, depth = 2^ADDR_W
//   ZERO_REG0 1: register 0 reads zero, drops writes, refuses reservations
//
// Ports:
//   Clock                    rising-edge clock
//   Clear                    synchronous active-high reset
//   ReadSelect1/2            read addresses
//   ReadData1/2              read data (combinational)
//   ReadBusy1/2              busy bit of the addressed register (combinational)
//   WriteSelect/Data/Enable  write port; a write releases a busy register
//   ReserveSelect/Enable     reservation request
//   ReserveAccept            reservation accepted this cycle (combinational)
//   BusyCount                number of busy registers (registered)

module regfile_scoreboard #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int ZERO_REG0 = 0
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] ReadSelect1,
    input  logic [ADDR_W-1:0] ReadSelect2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ReadBusy1,
    output logic              ReadBusy2,
    input  logic [ADDR_W-1:0] WriteSelect,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] ReserveSelect,
    input  logic              ReserveEnable,
    output logic              ReserveAccept,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam bit Z0    = (ZERO_REG0 != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic write_ok;
    logic release_w;

    // Writes to a hard-wired zero register are dropped entirely.
    assign write_ok  = WriteEnable && !(Z0 && (WriteSelect == '0));
    // Register 0 can never be busy when hard-wired, so a dropped write
    // never needs to release anything.
    assign release_w = write_ok && busy[WriteSelect];

    // Uses start-of-cycle busy state: a same-cycle write to a busy register
    // releases it and this request is rejected.
    assign ReserveAccept = ReserveEnable && !busy[ReserveSelect]
                           && !(Z0 && (ReserveSelect == '0));

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            BusyCount <= '0;
        end else begin
            if (write_ok) begin
                regs[WriteSelect] <= WriteData;
                busy[WriteSelect] <= 1'b0;
            end
            // Accept and release on the same register are mutually exclusive
            // (accept needs idle, release needs busy), so ordering is safe.
            if (ReserveAccept) begin
                busy[ReserveSelect] <= 1'b1;
            end
            BusyCount <= BusyCount + CNT_W'(ReserveAccept) - CNT_W'(release_w);
        end
    end

    always_comb begin
        ReadData1 = regs[ReadSelect1];
        ReadBusy1 = busy[ReadSelect1];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        if (write_ok && (WriteSelect == ReadSelect1)) begin
            ReadData1 = WriteData;
            ReadBusy1 = 1'b0;
        end
`endif
        if (Z0 && (ReadSelect1 == '0)) begin
            ReadData1 = '0;
            ReadBusy1 = 1'b0;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadSelect2];
        ReadBusy2 = busy[ReadSelect2];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        if (write_ok && (WriteSelect == ReadSelect2)) begin
            ReadData2 = WriteData;
            ReadBusy2 = 1'b0;
        end
`endif
        if (Z0 && (ReadSelect2 == '0)) begin
            ReadData2 = '0;
            ReadBusy2 = 1'b0;
        end
    end

endmodule
